// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
// States, settle-counter width and the table-width helper.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam int CNT_W = 4;

  function automatic int tbl_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/scan_settle_cnt.sv
// Settle counter: counts the hold cycles of one vector.
// With SETTLE = 0 no counter exists and tc is always high.
module scan_settle_cnt
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  if (SETTLE == 0) begin : g_zero
    logic unused_in;
    assign unused_in = clk ^ rst_n ^ clr ^ en;
    assign tc = 1'b1;
  end else begin : g_cnt
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
    end

    // cnt = k-1 during the k-th drive cycle
    assign tc = (cnt == LAST);
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives all input vectors of a function and captures its truth table.
// Define SCAN_COMPARE_EN to enable compare against the expected mask.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [tbl_w(N_IN)-1:0] expected,
  output logic [N_IN-1:0]        vec_o,
  input  logic                   s_i,
  output logic                   busy,
  output logic                   done,
  output logic [tbl_w(N_IN)-1:0] table_o,
  output logic                   mismatch,
  output logic [N_IN-1:0]        first_fail
);

  localparam int TW = tbl_w(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t state;
  state_t state_d;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] idx_d;
  logic tc;
  logic last;
  logic accept;
  logic capture;
  logic busy_d;

  assign last    = (idx == LAST_IDX);
  assign accept  = (state == IDLE) && start && !abort;
  assign capture = (state == SAMPLE) && !abort;
  assign busy_d  = (state_d == DRIVE) || (state_d == SAMPLE);

  scan_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != DRIVE),
    .en   (state == DRIVE),
    .tc   (tc)
  );

  always_comb begin
    state_d = state;
    idx_d   = idx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          idx_d = '0;
          if (SETTLE == 0) state_d = SAMPLE;
          else             state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (abort)   state_d = IDLE;
        else if (tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DONE;
        end else begin
          idx_d = idx + 1'b1;
          if (SETTLE == 0) state_d = SAMPLE;
          else             state_d = DRIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so done lands with DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      vec_o   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      table_o <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      busy  <= busy_d;
      done  <= (state_d == DONE);
      vec_o <= busy_d ? idx_d : '0;
      if (accept) begin
        table_o <= '0;
      end else if (capture) begin
        table_o[idx] <= s_i;
      end
    end
  end

`ifdef SCAN_COMPARE_EN
  logic [TW-1:0] exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      mismatch   <= 1'b0;
      first_fail <= '0;
    end else if (accept) begin
      exp_q      <= expected;
      mismatch   <= 1'b0;
      first_fail <= '0;
    end else if (capture && !mismatch && (s_i != exp_q[idx])) begin
      mismatch   <= 1'b1;
      first_fail <= idx;
    end
  end
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign mismatch   = 1'b0;
  assign first_fail = '0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner (SETTLE=1 and SETTLE=0 instances).
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, abort0, s0, busy0, done0, mm0;
  logic [7:0] exp0, tbl0;
  logic [2:0] vec0, ff0;
  logic       start1, abort1, s1, busy1, done1, mm1;
  logic [7:0] exp1, tbl1;
  logic [2:0] vec1, ff1;
  int         fsel;
  int         checks = 0;
  int         errors = 0;

`ifdef SCAN_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .expected(exp0), .vec_o(vec0), .s_i(s0), .busy(busy0),
    .done(done0), .table_o(tbl0), .mismatch(mm0), .first_fail(ff0)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(exp1), .vec_o(vec1), .s_i(s1), .busy(busy1),
    .done(done1), .table_o(tbl1), .mismatch(mm1), .first_fail(ff1)
  );

  // Functions under test: a,b,c = vec[2],vec[1],vec[0]
  always_comb begin
    s0 = 1'b0;
    case (fsel)
      0: s0 = (vec0[2] & ~vec0[0]) | (vec0[2] & ~vec0[1] & vec0[0]);
      1: s0 = vec0[2] ^ vec0[1] ^ vec0[0];
      default: s0 = ~vec0[2];
    endcase
  end
  assign s1 = vec1[2] ^ vec1[1] ^ vec1[0];

  task automatic start_scan0(input logic [7:0] e);
    @(negedge clk);
    exp0 = e;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int k0, output int k);
    k = k0;
    while (done0 !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (done0 !== 1'b1) k = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start0 = 0; abort0 = 0; exp0 = '0; fsel = 0;
    start1 = 0; abort1 = 0; exp1 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({vec0, busy0, done0, tbl0, mm0, ff0} !== 17'h0) begin
      errors++;
      $display("FAIL reset0: got %h required 0",
               {vec0, busy0, done0, tbl0, mm0, ff0});
    end
    checks++;
    if ({vec1, busy1, done1, tbl1, mm1, ff1} !== 17'h0) begin
      errors++;
      $display("FAIL reset1: got %h required 0",
               {vec1, busy1, done1, tbl1, mm1, ff1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan_pass;
    fsel = 0;
    start_scan0(8'h70);
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (vec0 !== 3'((k - 1) / 2) || busy0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL seq k=%0d: vec=%0d busy=%b done=%b required vec=%0d busy=1 done=0",
                 k, vec0, busy0, done0, (k - 1) / 2);
      end
      @(negedge clk);
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || vec0 !== 3'd0) begin
      errors++;
      $display("FAIL done_t17: done=%b busy=%b vec=%0d required 1 0 0",
               done0, busy0, vec0);
    end
    checks++;
    if (tbl0 !== 8'h70 || mm0 !== 1'b0) begin
      errors++;
      $display("FAIL pass_tbl: tbl=%h mm=%b required 70 0", tbl0, mm0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || tbl0 !== 8'h70) begin
      errors++;
      $display("FAIL pulse: done=%b tbl=%h required 0 70", done0, tbl0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mismatch(input logic [7:0] e, input logic [2:0] ff_exp);
    int k;
    fsel = 0;
    start_scan0(e);
    wait_done0(1, k);
    checks++;
    if (k !== 17) begin
      errors++;
      $display("FAIL mm_done_k: got %0d required 17", k);
    end
    checks++;
    if (tbl0 !== 8'h70 || mm0 !== CMP || ff0 !== (CMP ? ff_exp : 3'd0)) begin
      errors++;
      $display("FAIL mm_%h: tbl=%h mm=%b ff=%0d required 70 %b %0d",
               e, tbl0, mm0, ff0, CMP, CMP ? ff_exp : 3'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_settle0;
    int k;
    @(negedge clk);
    exp1 = 8'h96;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 1;
    while (done1 !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (done1 !== 1'b1) k = -1;
    checks++;
    if (k !== 9) begin
      errors++;
      $display("FAIL s0_done_k: got %0d required 9", k);
    end
    checks++;
    if (tbl1 !== 8'h96 || mm1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL s0_tbl: tbl=%h mm=%b busy=%b required 96 0 0",
               tbl1, mm1, busy1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort;
    int k;
    int pulses;
    fsel = 2;
    start_scan0(8'h0F);
    k = 1;
    while (vec0 !== 3'd3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 7) begin
      errors++;
      $display("FAIL ab_vec3_k: got %0d required 7", k);
    end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || vec0 !== 3'd0 || done0 !== 1'b0 || tbl0 !== 8'h07) begin
      errors++;
      $display("FAIL abort: busy=%b vec=%0d done=%b tbl=%h required 0 0 0 07",
               busy0, vec0, done0, tbl0);
    end
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL ab_quiet: got %0d active cycles required 0", pulses);
    end
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || tbl0 !== 8'h07) begin
      errors++;
      $display("FAIL start_abort: busy=%b tbl=%h required 0 07", busy0, tbl0);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_reset;
    int k;
    int act;
    fsel = 0;
    start_scan0(8'h70);
    repeat (4) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(6, k);
    checks++;
    if (k !== 17 || tbl0 !== 8'h70) begin
      errors++;
      $display("FAIL restart: k=%0d tbl=%h required 17 70", k, tbl0);
    end
    repeat (2) @(negedge clk);
    start_scan0(8'h70);
    repeat (11) @(negedge clk);
    checks++;
    if (tbl0 !== 8'h10 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL partial: tbl=%h busy=%b required 10 1", tbl0, busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({vec0, busy0, done0, tbl0, mm0, ff0} !== 17'h0) begin
      errors++;
      $display("FAIL async_rst: got %h required 0",
               {vec0, busy0, done0, tbl0, mm0, ff0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL rst_idle: got %0d active cycles required 0", act);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    fsel = 0;
    start_scan0(8'h70);
    wait_done0(1, k);
    @(negedge clk);
    fsel = 1;
    exp0 = 8'h96;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || tbl0 !== 8'h00) begin
      errors++;
      $display("FAIL b2b_start: busy=%b tbl=%h required 1 00", busy0, tbl0);
    end
    wait_done0(1, k);
    checks++;
    if (k !== 17 || tbl0 !== 8'h96 || mm0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b: k=%0d tbl=%h mm=%b required 17 96 0", k, tbl0, mm0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan_pass();
    test_mismatch(8'hF0, 3'd7);
    test_mismatch(8'h00, 3'd4);
    test_settle0();
    test_abort();
    test_restart_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus/capture stage for the small combinational functions in the design, such as the 3-input `s = f(a,b,c)` gate networks. The block sits directly upstream of the function under test and drives every input combination in ascending binary order. It samples the function's single output back after a programmable settle time and assembles the full truth table as a bit vector. It optionally compares that table against an expected minterm mask, replacing the hand-written `$display` sweeps with a reusable, synthesizable stage.

## Interface
- `N_IN`, default 3: number of function inputs; the table width is `2**N_IN`. Legal range is 1..6.
- `SETTLE`, default 1: number of cycles `vec_o` is held before `s_i` is sampled. Legal range is 0..15.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a scan; honoured only in IDLE.
- `abort`  in  1  terminate a scan in progress.
- `expected`  in  `2**N_IN`  expected truth table, bit i = f(i); captured at start.
- `vec_o`  out  `N_IN`  function inputs; MSB = `a`, LSB = last input.
- `s_i`  in  1  function output, sampled back.
- `busy`  out  1  high from the cycle after an accepted start until the done cycle.
- `done`  out  1  single-cycle pulse; scan complete.
- `table_o`  out  `2**N_IN`  captured truth table, bit i = `s_i` sampled with `vec_o` = i.
- `mismatch`  out  1  table differs from expected; valid from the done cycle.
- `first_fail`  out  `N_IN`  lowest failing index; valid when mismatch = 1.

## Operation
- FSM states are IDLE, DRIVE, SAMPLE and DONE.
- IDLE:
  - On `start`, clear `table_o`, `mismatch` and `first_fail`, capture `expected`, and load index and `vec_o` with 0.
  - Go to DRIVE, or to SAMPLE if `SETTLE` = 0.
- DRIVE: the settle counter runs 1..`SETTLE`. Go to SAMPLE after `SETTLE` cycles.
- SAMPLE:
  - Write `table_o[idx]` <= `s_i`.
  - If `s_i` != `expected[idx]` and no failure has been latched yet, set `mismatch` and latch `first_fail` <= idx.
  - If idx = `2**N_IN`-1, go to DONE. Otherwise increment idx and `vec_o` and return to DRIVE, or stay in SAMPLE if `SETTLE` = 0.
- DONE: assert `done` for one cycle, drive `vec_o` to 0, and return to IDLE.
- Results (`table_o`, `mismatch`, `first_fail`) hold until the next accepted start.
- `start` while `busy` is ignored.
- `start` and `abort` together in IDLE: abort wins and the scan does not begin.
- `abort` in DRIVE or SAMPLE:
  - Go to IDLE on the next edge with no `done` pulse.
  - `vec_o` goes to 0 and `busy` falls.
  - `table_o` keeps its partial contents; `mismatch`/`first_fail` keep any value already latched.
- `abort` in the DONE cycle has no effect; the done pulse completes.
- Index wrap-around never occurs: the last index exits to DONE.

## Timing
- Reset values: `vec_o` = 0, `busy` = 0, `done` = 0, `table_o` = 0, `mismatch` = 0, `first_fail` = 0; FSM in IDLE.
- Reset takes effect immediately, mid-scan included. No done pulse is produced.
- `start` sampled at edge T0: `busy` = 1 and `vec_o` = 0 from T0+1.
- Each vector occupies `SETTLE`+1 cycles. `s_i` is sampled at the last edge of that window.
- With `SETTLE` = 0, `s_i` must settle combinationally within the same cycle.
- `done` asserts at T0 + `2**N_IN`·(`SETTLE`+1) + 1. With defaults this is T0+17. `busy` falls in the same cycle.
- All outputs are registered.

## Configuration
- `SCAN_COMPARE_EN` defined:
  - `expected` is captured at start.
  - `mismatch` and `first_fail` operate as described in Operation.
- `SCAN_COMPARE_EN` undefined:
  - The ports remain present.
  - `expected` is ignored.
  - `mismatch` and `first_fail` are tied to 0.
  - No compare logic or expected register is synthesized.

## Structure
- Package `truth_table_scanner_pkg` holds:
  - the state enum (IDLE/DRIVE/SAMPLE/DONE);
  - the settle-counter width constant (4 bits);
  - the function `tbl_w(n)` = `2**n`.
- Sub-module `scan_settle_cnt` implements the settle counter: load/clear, terminal-count flag, degenerate behaviour for `SETTLE` = 0.
- The FSM, index register and capture logic stay in the top module.

## Test plan
- Defaults, DUT `s = a·~c + a·~b·c`, `expected` = 8'h70, start pulse → `vec_o` steps 0..7 every 2 cycles; `done` at T0+17; `table_o` = 8'h70; `mismatch` = 0.
- Same setup with `expected` = 8'hF0 → `table_o` = 8'h70, `mismatch` = 1, `first_fail` = 7.
- `SETTLE` = 0, DUT s = a XOR b XOR c → `done` at T0+9; `table_o` = 8'h96.
- Abort asserted while `vec_o` = 3 → no `done`; `busy` = 0 next cycle; `vec_o` = 0; `table_o[2:0]` holds captured bits and `table_o[7:3]` = 0.
- `start` re-pulsed mid-scan, then `rst_n` low mid-scan → second start ignored (done still at T0+17); reset clears all outputs immediately and the FSM returns to IDLE.
- `SCAN_COMPARE_EN` undefined, `expected` = 8'h00 with a nonzero DUT → `mismatch` = 0, `first_fail` = 0, `table_o` correct.
